// File: rtl/imm_ext_pkg.sv
// Shared mode encodings for the immediate-extension stage and its decoder.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'd0,
    MODE_ZERO   = 2'd1,
    MODE_UPPER  = 2'd2,
    MODE_BRANCH = 2'd3
  } imm_mode_t;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle between instruction decode (master) and the extension stage (slave).
import imm_ext_pkg::*;

interface imm_ext_pipe_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  imm_in;
  imm_mode_t        mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] imm_out;
  imm_mode_t        out_mode;

  modport master (
    output flush, in_valid, imm_in, mode, out_ready,
    input  in_ready, out_valid, imm_out, out_mode
  );

  modport slave (
    input  flush, in_valid, imm_in, mode, out_ready,
    output in_ready, out_valid, imm_out, out_mode
  );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: (imm, mode) -> full-width operand.
import imm_ext_pkg::*;

module imm_ext_core #(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic [IN_W-1:0]  imm,
  input  imm_mode_t        mode,
  output logic [OUT_W-1:0] ext
);

  if (OUT_W < IN_W + BR_SHIFT) begin : g_param_check
    $error("imm_ext_core: OUT_W must be >= IN_W + BR_SHIFT");
  end

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;

  // Size casts avoid a zero-width replication when OUT_W == IN_W.
  assign sext = OUT_W'($signed(imm));
  assign zext = OUT_W'(imm);

  always_comb begin
    ext = '0;
    unique case (mode)
      MODE_SIGN:   ext = sext;
      MODE_ZERO:   ext = zext;
      MODE_UPPER:  ext = zext << (OUT_W - IN_W);
      MODE_BRANCH: ext = sext << BR_SHIFT;
      default:     ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer on the output.
import imm_ext_pkg::*;

module imm_ext_pipe #(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic          clk,
  input  logic          rst,
  imm_ext_pipe_if.slave bus
);

  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] main_data;
  logic [OUT_W-1:0] skid_data;
  imm_mode_t        main_mode;
  imm_mode_t        skid_mode;
  logic             main_valid;
  logic             skid_valid;
  logic             accept;
  logic             drain;

  imm_ext_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .BR_SHIFT(BR_SHIFT)
  ) u_core (
    .imm (bus.imm_in),
    .mode(bus.mode),
    .ext (ext)
  );

  assign accept = bus.in_valid && bus.in_ready;
  assign drain  = main_valid && bus.out_ready;

  // in_ready only reflects skid occupancy, so it never waits on out_ready.
  assign bus.in_ready  = !skid_valid && !rst;
  assign bus.out_valid = main_valid;
  assign bus.imm_out   = main_data;
  assign bus.out_mode  = main_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      main_mode  <= MODE_SIGN;
      skid_mode  <= MODE_SIGN;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain || !main_valid) begin
      // Main is free this edge: skid has priority (no accept possible while it is full).
      if (skid_valid) begin
        main_data  <= skid_data;
        main_mode  <= skid_mode;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_data  <= ext;
        main_mode  <= bus.mode;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data  <= ext;
      skid_mode  <= bus.mode;
      skid_valid <= 1'b1;
    end
  end

endmodule
